// File: rtl/ex_div_unit.sv
// Iterative restoring divider (signed/unsigned) for the EX stage: WIDTH CALC cycles, one FIX cycle, one DONE pulse.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor bypasses CALC/FIX and completes in one cycle.
module ex_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Handshake: start is accepted only in IDLE or DONE with cancel low; busy
  // is high from the cycle after acceptance until results are written, and
  // done pulses for one cycle when quotient/remainder become valid.
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q, r_neg_r;
  logic [WIDTH-1:0] r_quotient, r_remainder;
  logic             r_busy, r_done;

  logic             w_accept, w_dvz, w_dvd_neg, w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
  logic [WIDTH:0]   w_shift, w_diff;

  assign w_accept  = start && !cancel && (r_state == S_IDLE || r_state == S_DONE);
  assign w_dvz     = (divisor == '0);
  assign w_dvd_neg = signed_op && dividend[WIDTH-1];
  assign w_dvs_neg = signed_op && divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag = w_dvs_neg ? -divisor : divisor;

  // One restoring step: shift the next dividend bit in and trial-subtract.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_next = S_IDLE;
        if (w_accept) begin
`ifdef DIV_ZERO_FAST_EN
          w_next = w_dvz ? S_DONE : S_CALC;
`else
          w_next = S_CALC;
`endif
        end
      end
      S_CALC:  if (r_cnt == CW'(1)) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (cancel) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rem   <= '0;
        r_quo   <= w_dvd_mag;
        r_dvs   <= w_dvs_mag;
        r_cnt   <= CW'(WIDTH);
        // A zero divisor leaves quo all ones; only the remainder is re-signed,
        // which restores the original dividend.
        r_neg_q <= (w_dvd_neg ^ w_dvs_neg) && !w_dvz;
        r_neg_r <= w_dvd_neg;
`ifdef DIV_ZERO_FAST_EN
        if (w_dvz) begin
          r_quotient  <= '1;
          r_remainder <= dividend;
        end
`endif
      end else if (r_state == S_CALC && !cancel) begin
        if (!w_diff[WIDTH]) begin
          r_rem <= w_diff[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b1};
        end else begin
          r_rem <= w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b0};
        end
        r_cnt <= r_cnt - CW'(1);
      end else if (r_state == S_FIX && !cancel) begin
        r_quotient  <= r_neg_q ? -r_quo : r_quo;
        r_remainder <= r_neg_r ? -r_rem : r_rem;
      end
      r_busy <= (w_next == S_CALC) || (w_next == S_FIX);
      r_done <= (w_next == S_DONE);
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: driver tasks push expected results, a done monitor pops and compares.
module tb_ex_div_unit;
  localparam int W   = 32;
  localparam int LAT = W + 2;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = W + 2;
`endif

  logic         clk = 1'b0;
  logic         rst, start, signed_op, cancel;
  logic [W-1:0] dividend, divisor;
  logic         busy, done;
  logic [W-1:0] quotient, remainder;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r[$];
  int           exp_c[$];

  ex_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .cancel(cancel),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .o_dbg_state(dbg_state)
  );

  // clock / reset / cycle index
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents start for one cycle; returns one cycle later.
  task automatic launch(input logic sop, input logic [W-1:0] dd, input logic [W-1:0] dv);
    start = 1'b1; signed_op = sop; dividend = dd; divisor = dv;
    step(1);
    start = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] q, input logic [W-1:0] r, input int c);
    exp_q.push_back(q);
    exp_r.push_back(r);
    exp_c.push_back(c);
  endtask

  task automatic run_div(input logic sop, input logic [W-1:0] dd, input logic [W-1:0] dv,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input int lat);
    push(eq, er, cyc + lat);
    launch(sop, dd, dv);
    if (lat > 1) begin
      check("busy_first", busy, 1'b1);
      step(lat - 2);
      check("busy_last", busy, 1'b1);
      step(1);
    end
    check("busy_done_cycle", busy, 1'b0);
    step(1);
  endtask

  // monitor: every done pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done cycle=%0d actual=1 required=0", cyc);
      end else begin
        check("quotient", quotient, exp_q.pop_front());
        check("remainder", remainder, exp_r.pop_front());
        check("done_cycle", cyc, exp_c.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; cancel = 1'b0;
    dividend = '0; divisor = '0;
    step(2);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    check("rst_state", dbg_state, 2'd0);
    rst = 1'b0;
    step(2);

    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, LAT);
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, LAT);
    run_div(1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, LAT);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, LAT);
    run_div(1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, ZLAT);
    run_div(1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, ZLAT);

    // cancel in cycle 10: no done, outputs hold the previous result
    launch(1'b0, 32'd100, 32'd7);
    step(9);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    check("cancel_busy", busy, 1'b0);
    check("cancel_state", dbg_state, 2'd0);
    step(40);
    check("cancel_hold_q", quotient, 32'hFFFFFFFF);
    check("cancel_hold_r", remainder, 32'hFFFFFFFB);

    // start together with cancel in IDLE is not accepted
    start = 1'b1; cancel = 1'b1; signed_op = 1'b0; dividend = 32'd50; divisor = 32'd5;
    step(1);
    start = 1'b0; cancel = 1'b0;
    check("startcancel_busy", busy, 1'b0);
    step(3);
    check("startcancel_busy_later", busy, 1'b0);
    check("startcancel_state", dbg_state, 2'd0);

    // back-to-back with ignored start pulses while busy
    push(32'd14, 32'd2, cyc + LAT);
    push(32'hFFFFFFFF, 32'd0, cyc + 2 * LAT);
    launch(1'b0, 32'd100, 32'd7);
    step(4);
    launch(1'b1, 32'd5, 32'd5);
    step(14);
    launch(1'b0, 32'd9, 32'd9);
    step(12);
    step(1);
    launch(1'b0, 32'hFFFFFFFF, 32'd1);
    check("b2b_busy_second", busy, 1'b1);
    step(W);
    check("b2b_busy_second_last", busy, 1'b1);
    step(1);
    check("b2b_busy_end", busy, 1'b0);
    step(2);

    // asynchronous reset in cycle 15 of a division
    launch(1'b0, 32'd77, 32'd5);
    step(13);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_quotient", quotient, '0);
    check("midrst_remainder", remainder, '0);
    step(1);
    rst = 1'b0;
    step(1);
    run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, LAT);
    step(2);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
